// File: rtl/lcd_text_timing.sv
// Pixel-rate raster timing for an 800x480 RGB LCD. Generates the sync, data-enable
// and character-cell coordinates. Every output is registered from the raster counters.
module lcd_text_timing #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 168,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 22,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 19,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned GLYPH_W  = 8,
  parameter int unsigned GLYPH_H  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] px,
  output logic [9:0]  py,
  output logic [6:0]  char_col,
  output logic [4:0]  char_row,
  output logic [2:0]  glyph_x,
  output logic [3:0]  glyph_y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned GXW     = $clog2(GLYPH_W);
  localparam int unsigned GYW     = $clog2(GLYPH_H);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_W  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_W  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ACT   = 1'(HS_POL);
  localparam logic          VS_ACT   = 1'(VS_POL);
  localparam logic [HW-1:0] GX_MASK  = HW'(GLYPH_W - 1);
  localparam logic [VW-1:0] GY_MASK  = VW'(GLYPH_H - 1);

  // Elaboration-time parameter sanity checks.
  if ((GLYPH_W == 0) || ((GLYPH_W & (GLYPH_W - 1)) != 0)) begin : g_bad_glyph_w
    $error("lcd_text_timing: GLYPH_W must be a power of 2");
  end
  if ((GLYPH_H == 0) || ((GLYPH_H & (GLYPH_H - 1)) != 0)) begin : g_bad_glyph_h
    $error("lcd_text_timing: GLYPH_H must be a power of 2");
  end
  if (H_TOTAL > 2047) begin : g_bad_h_total
    $error("lcd_text_timing: H_TOTAL exceeds the 11-bit counter");
  end
  if (V_TOTAL > 1023) begin : g_bad_v_total
    $error("lcd_text_timing: V_TOTAL exceeds the 10-bit counter");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [HW-1:0] px_q, px_d;
  logic [VW-1:0] py_q, py_d;
  logic [6:0]    char_col_q, char_col_d;
  logic [4:0]    char_row_q, char_row_d;
  logic [2:0]    glyph_x_q, glyph_x_d;
  logic [3:0]    glyph_y_q, glyph_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Raster counters: h wraps at end of line, v steps on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  // Decode of the current counter position into next output values.
  always_comb begin
    logic de_c;
    logic hs_on_c;
    logic vs_on_c;
    de_c          = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
    hs_on_c       = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_on_c       = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    de_d          = de_c;
    hsync_d       = hs_on_c ? HS_ACT : ~HS_ACT;
    vsync_d       = vs_on_c ? VS_ACT : ~VS_ACT;
    px_d          = de_c ? h_cnt_q : '0;
    py_d          = de_c ? v_cnt_q : '0;
    glyph_x_d     = 3'(px_d & GX_MASK);
    char_col_d    = 7'(px_d >> GXW);
    glyph_y_d     = 4'(py_d & GY_MASK);
    char_row_d    = 5'(py_d >> GYW);
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Outputs only refresh on enabled pixels, so pulses span one full pixel period.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      px_q          <= '0;
      py_q          <= '0;
      char_col_q    <= '0;
      char_row_q    <= '0;
      glyph_x_q     <= '0;
      glyph_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (pix_en) begin
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        de_q          <= de_d;
        px_q          <= px_d;
        py_q          <= py_d;
        char_col_q    <= char_col_d;
        char_row_q    <= char_row_d;
        glyph_x_q     <= glyph_x_d;
        glyph_y_q     <= glyph_y_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign px          = px_q;
  assign py          = py_q;
  assign char_col    = char_col_q;
  assign char_row    = char_row_q;
  assign glyph_x     = glyph_x_q;
  assign glyph_y     = glyph_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
